// File: rtl/mem_stage_ctrl.sv
// Memory-stage data access sequencer: runs the M-stage request over the req/addr_ok/data_ok
// bus, buffers load data, and generates mem_stall and the EX/MEM register enables and clears.
module mem_stage_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              M_mem_en,
   input  logic              M_mem_wen,
   input  logic [1:0]        M_mem_size,
   input  logic [ADDR_W-1:0] M_mem_addr,
   input  logic [DATA_W-1:0] M_mem_wdata,
   input  logic              M_flush,
   input  logic              E_stall_req,
   input  logic              E_slave_kill,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [DATA_W-1:0] data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [DATA_W-1:0] data_rdata,
   output logic [DATA_W-1:0] M_rdata,
   output logic              M_rdata_valid,
   output logic              mem_stall,
   output logic              exmem_ena1,
   output logic              exmem_ena2,
   output logic              exmem_clear1,
   output logic              exmem_clear2
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      DONE,
      DRAIN_REQ,
      DRAIN_WAIT
   } state_t;

   state_t              state;
   logic                lat_wr;
   logic [1:0]          lat_size;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata;
   logic [DATA_W-1:0]   rdata_buf;
   logic                issue;
   logic                stall;

   assign issue = M_mem_en & ~M_flush;

   // Bus fields come live from M only in the issuing IDLE cycle; afterwards the latched copy
   // keeps them stable until addr_ok, whatever the M-stage inputs do.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      data_req   = 1'b0;
      data_wr    = lat_wr;
      data_size  = lat_size;
      data_addr  = lat_addr;
      data_wdata = lat_wdata;
      unique case (state)
         IDLE: begin
            if (issue) begin
               data_req   = 1'b1;
               data_wr    = M_mem_wen;
               data_size  = M_mem_size;
               data_addr  = M_mem_addr;
               data_wdata = M_mem_wdata;
            end
         end
         REQ, DRAIN_REQ: data_req = 1'b1;
         default: ;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         lat_wr    <= 1'b0;
         lat_size  <= 2'd0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rdata_buf <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (issue) begin
                  lat_wr    <= M_mem_wen;
                  lat_size  <= M_mem_size;
                  lat_addr  <= M_mem_addr;
                  lat_wdata <= M_mem_wdata;
                  state     <= data_addr_ok ? WAIT : REQ;
               end
            end
            REQ: begin
               if (data_addr_ok)  state <= M_flush ? DRAIN_WAIT : WAIT;
               else if (M_flush)  state <= DRAIN_REQ;
            end
            WAIT: begin
               if (data_data_ok) begin
                  if (M_flush) begin
                     state <= IDLE;
                  end else begin
                     if (!lat_wr) rdata_buf <= data_rdata;
                     state <= DONE;
                  end
               end else if (M_flush) begin
                  state <= DRAIN_WAIT;
               end
            end
            DONE: begin
               if (!E_stall_req || M_flush) state <= IDLE;
            end
            // A requested transaction always completes; the drain just swallows its response.
            DRAIN_REQ: begin
               if (data_addr_ok) state <= DRAIN_WAIT;
            end
            DRAIN_WAIT: begin
               if (data_data_ok) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mem_stall     = M_mem_en & (state != DONE) & ~M_flush;
   assign stall         = mem_stall | E_stall_req;
   assign exmem_ena1    = ~stall;
   assign exmem_ena2    = ~stall;
   // EX holding while M drains must push a bubble into M rather than repeat the instruction.
   assign exmem_clear1  = M_flush | (E_stall_req & ~mem_stall);
   assign exmem_clear2  = exmem_clear1 | (E_slave_kill & ~stall);
   assign M_rdata       = rdata_buf;
   assign M_rdata_valid = (state == DONE);

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: hand-computed vectors, immediate assertions per check.
module tb_mem_stage_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        M_mem_en, M_mem_wen, M_flush, E_stall_req, E_slave_kill;
   logic [1:0]  M_mem_size;
   logic [31:0] M_mem_addr, M_mem_wdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic [31:0] M_rdata;
   logic        M_rdata_valid, mem_stall;
   logic        exmem_ena1, exmem_ena2, exmem_clear1, exmem_clear2;

   int vectors = 0;
   int miscompares = 0;

   mem_stage_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .M_mem_en(M_mem_en), .M_mem_wen(M_mem_wen), .M_mem_size(M_mem_size),
      .M_mem_addr(M_mem_addr), .M_mem_wdata(M_mem_wdata),
      .M_flush(M_flush), .E_stall_req(E_stall_req), .E_slave_kill(E_slave_kill),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .M_rdata(M_rdata), .M_rdata_valid(M_rdata_valid), .mem_stall(mem_stall),
      .exmem_ena1(exmem_ena1), .exmem_ena2(exmem_ena2),
      .exmem_clear1(exmem_clear1), .exmem_clear2(exmem_clear2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are then changed 1 time unit after the edge and outputs
   // are checked 1 more unit later, well away from the next edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst = 1'b1; M_mem_en = 0; M_mem_wen = 0; M_mem_size = 2'd0; M_mem_addr = 0;
      M_mem_wdata = 0; M_flush = 0; E_stall_req = 0; E_slave_kill = 0;
      data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
      step(); step();
      rst = 1'b0;
      settle();
      check("rst_req",    {31'd0, data_req},      32'd0);
      check("rst_rdata",  M_rdata,                32'd0);
      check("rst_valid",  {31'd0, M_rdata_valid}, 32'd0);
      check("rst_stall",  {31'd0, mem_stall},     32'd0);
      check("rst_ena1",   {31'd0, exmem_ena1},    32'd1);
      check("rst_clear2", {31'd0, exmem_clear2},  32'd0);

      // Best-case load
      step();
      M_mem_en = 1; M_mem_wen = 0; M_mem_size = 2'd2; M_mem_addr = 32'h100; data_addr_ok = 1;
      settle();
      check("ld_c0_req",   {31'd0, data_req},  32'd1);
      check("ld_c0_addr",  data_addr,          32'h100);
      check("ld_c0_wr",    {31'd0, data_wr},   32'd0);
      check("ld_c0_size",  {30'd0, data_size}, 32'd2);
      check("ld_c0_stall", {31'd0, mem_stall}, 32'd1);
      step();
      data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hDEADBEEF;
      settle();
      check("ld_c1_stall", {31'd0, mem_stall},     32'd1);
      check("ld_c1_req",   {31'd0, data_req},      32'd0);
      check("ld_c1_valid", {31'd0, M_rdata_valid}, 32'd0);
      step();
      data_data_ok = 0; data_rdata = 32'h0;
      settle();
      check("ld_c2_stall", {31'd0, mem_stall},     32'd0);
      check("ld_c2_valid", {31'd0, M_rdata_valid}, 32'd1);
      check("ld_c2_rdata", M_rdata,                32'hDEADBEEF);
      check("ld_c2_ena1",  {31'd0, exmem_ena1},    32'd1);
      check("ld_c2_clr1",  {31'd0, exmem_clear1},  32'd0);
      step();
      M_mem_en = 0;
      settle();
      check("ld_c3_valid", {31'd0, M_rdata_valid}, 32'd0);
      check("ld_c3_rdata", M_rdata,                32'hDEADBEEF);

      // Store with addr_ok held low for 3 cycles; M inputs change underneath
      step();
      M_mem_en = 1; M_mem_wen = 1; M_mem_size = 2'd1; M_mem_addr = 32'h200;
      M_mem_wdata = 32'hA5A5A5A5; data_addr_ok = 0;
      settle();
      for (int c = 0; c < 4; c++) begin
         check("st_req",   {31'd0, data_req},  32'd1);
         check("st_wr",    {31'd0, data_wr},   32'd1);
         check("st_size",  {30'd0, data_size}, 32'd1);
         check("st_addr",  data_addr,          32'h200);
         check("st_wdata", data_wdata,         32'hA5A5A5A5);
         check("st_stall", {31'd0, mem_stall}, 32'd1);
         step();
         M_mem_addr = 32'h300 + c; M_mem_wdata = 32'h11111111; M_mem_size = 2'd0;
         M_mem_wen = 0;
         data_addr_ok = (c == 2);
         settle();
      end
      // now in WAIT
      data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hFFFFFFFF;
      settle();
      check("st_wait_req",   {31'd0, data_req},  32'd0);
      check("st_wait_stall", {31'd0, mem_stall}, 32'd1);
      step();
      data_data_ok = 0;
      settle();
      check("st_done_valid", {31'd0, M_rdata_valid}, 32'd1);
      check("st_done_buf",   M_rdata,                32'hDEADBEEF);
      step();
      M_mem_en = 0;
      settle();

      // Load into DONE while EX stalls for 2 cycles
      step();
      M_mem_en = 1; M_mem_wen = 0; M_mem_size = 2'd2; M_mem_addr = 32'h400; data_addr_ok = 1;
      settle();
      check("es_c0_req", {31'd0, data_req}, 32'd1);
      step();
      data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hCAFEF00D;
      settle();
      step();
      data_data_ok = 0; E_stall_req = 1;
      settle();
      for (int c = 0; c < 2; c++) begin
         check("es_valid", {31'd0, M_rdata_valid}, 32'd1);
         check("es_rdata", M_rdata,                32'hCAFEF00D);
         check("es_req",   {31'd0, data_req},      32'd0);
         check("es_stall", {31'd0, mem_stall},     32'd0);
         check("es_clr1",  {31'd0, exmem_clear1},  32'd1);
         check("es_ena1",  {31'd0, exmem_ena1},    32'd0);
         step();
         settle();
      end
      E_stall_req = 0;
      settle();
      check("es_rel_valid", {31'd0, M_rdata_valid}, 32'd1);
      check("es_rel_ena1",  {31'd0, exmem_ena1},    32'd1);
      check("es_rel_clr1",  {31'd0, exmem_clear1},  32'd0);
      step();
      M_mem_en = 0;
      settle();
      check("es_idle_valid", {31'd0, M_rdata_valid}, 32'd0);

      // Flush in WAIT, response arrives two cycles later and is discarded
      step();
      M_mem_en = 1; M_mem_addr = 32'h500; data_addr_ok = 1;
      settle();
      step();
      data_addr_ok = 0; M_flush = 1;
      settle();
      check("fl_clr1",  {31'd0, exmem_clear1}, 32'd1);
      check("fl_clr2",  {31'd0, exmem_clear2}, 32'd1);
      check("fl_stall", {31'd0, mem_stall},    32'd0);
      step();
      M_flush = 0; M_mem_addr = 32'h600;
      settle();
      check("fl_d0_stall", {31'd0, mem_stall},     32'd1);
      check("fl_d0_req",   {31'd0, data_req},      32'd0);
      check("fl_d0_valid", {31'd0, M_rdata_valid}, 32'd0);
      step();
      data_data_ok = 1; data_rdata = 32'h12345678;
      settle();
      check("fl_d1_stall", {31'd0, mem_stall},     32'd1);
      check("fl_d1_valid", {31'd0, M_rdata_valid}, 32'd0);
      step();
      data_data_ok = 0; data_addr_ok = 1;
      settle();
      check("fl_new_req",   {31'd0, data_req},      32'd1);
      check("fl_new_addr",  data_addr,              32'h600);
      check("fl_new_valid", {31'd0, M_rdata_valid}, 32'd0);
      check("fl_buf",       M_rdata,                32'hCAFEF00D);
      step();
      data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h0BADF00D;
      settle();
      step();
      data_data_ok = 0;
      settle();
      check("fl_done_rdata", M_rdata,                32'h0BADF00D);
      check("fl_done_valid", {31'd0, M_rdata_valid}, 32'd1);
      step();
      M_mem_en = 0;
      settle();

      // Slave kill without and with an EX stall
      E_slave_kill = 1;
      settle();
      check("sk_clr2", {31'd0, exmem_clear2}, 32'd1);
      check("sk_clr1", {31'd0, exmem_clear1}, 32'd0);
      check("sk_ena2", {31'd0, exmem_ena2},   32'd1);
      E_stall_req = 1;
      settle();
      check("sks_clr2", {31'd0, exmem_clear2}, 32'd1);
      check("sks_ena1", {31'd0, exmem_ena1},   32'd0);
      check("sks_ena2", {31'd0, exmem_ena2},   32'd0);
      E_slave_kill = 0; E_stall_req = 0;

      // Reset while in REQ
      step();
      M_mem_en = 1; M_mem_addr = 32'h700; data_addr_ok = 0;
      settle();
      step();
      settle();
      check("rq_req", {31'd0, data_req}, 32'd1);
      rst = 1;
      step();
      rst = 0; M_mem_en = 0;
      settle();
      check("rr_req",   {31'd0, data_req},      32'd0);
      check("rr_rdata", M_rdata,                32'd0);
      check("rr_valid", {31'd0, M_rdata_valid}, 32'd0);
      check("rr_ena1",  {31'd0, exmem_ena1},    32'd1);
      check("rr_ena2",  {31'd0, exmem_ena2},    32'd1);
      check("rr_clr1",  {31'd0, exmem_clear1},  32'd0);
      check("rr_clr2",  {31'd0, exmem_clear2},  32'd0);
      M_mem_en = 1; M_mem_addr = 32'h800;
      settle();
      check("rr_new_addr", data_addr, 32'h800);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Sequences the memory-stage data access of the dual-issue pipeline and drives the EX→MEM pipeline register control pins. It takes the M-stage memory request (`M_mem_*`) and runs it over the SRAM-like data bus with a req/addr_ok/data_ok handshake. It holds returned load data and generates `mem_stall` plus the `ena1/ena2/clear1/clear2` lines of the EX/MEM register, covering EX stalls, slave-issue kills and exception flushes.

## Interface
- `ADDR_W`, 32, data bus address width
- `DATA_W`, 32, data bus data width
- `clk` in 1: single clock, all state updates on posedge
- `rst` in 1: synchronous, active-high; all state cleared on posedge with `rst`=1
- `M_mem_en` in 1: M-stage instruction performs a memory access
- `M_mem_wen` in 1: access is a store (else load)
- `M_mem_size` in 2: 0=byte, 1=half, 2=word
- `M_mem_addr` in ADDR_W: access address
- `M_mem_wdata` in DATA_W: store data
- `M_flush` in 1: exception/eret flush of all stages
- `E_stall_req` in 1: EX stage needs another cycle (multi-cycle ALU op)
- `E_slave_kill` in 1: slave EX instruction must not enter MEM
- `data_req`, `data_wr` out 1; `data_size` out 2: bus request, write flag, size
- `data_addr` out ADDR_W; `data_wdata` out DATA_W
- `data_addr_ok`, `data_data_ok` in 1; `data_rdata` in DATA_W
- `M_rdata` out DATA_W; `M_rdata_valid` out 1: buffered load result for MEM/WB
- `mem_stall` out 1: M stage cannot advance
- `exmem_ena1`, `exmem_ena2`, `exmem_clear1`, `exmem_clear2` out 1

## Operation
- States: IDLE, REQ, WAIT, DONE, DRAIN_REQ, DRAIN_WAIT. Reset: IDLE, rdata buffer 0, latched request 0.
- IDLE with `M_mem_en & ~M_flush`: `data_req`=1 with live `M_mem_*` fields, which are also latched. `addr_ok`=1 → WAIT, else → REQ.
- REQ: `data_req`=1 with the latched fields. `data_req` never drops before `addr_ok`. `addr_ok` → WAIT. `M_flush` without `addr_ok` → DRAIN_REQ. `M_flush` with `addr_ok` → DRAIN_WAIT.
- WAIT: `data_ok` → capture `data_rdata` into the buffer, go to DONE. `M_flush` without `data_ok` → DRAIN_WAIT. `M_flush` with `data_ok` → IDLE, data discarded.
- DONE: `M_rdata_valid`=1, `M_rdata`=buffer (stores: buffer unchanged, valid still 1). Leave to IDLE when `~E_stall_req | M_flush`, i.e. when M advances or is flushed.
- DRAIN_REQ: `data_req`=1 with latched fields. `addr_ok` → DRAIN_WAIT. A bus transaction is never cancelled once requested.
- DRAIN_WAIT: `data_ok` → IDLE, response discarded, buffer not written.
- `mem_stall` = `M_mem_en` & (state ∈ {IDLE, REQ, WAIT, DRAIN_REQ, DRAIN_WAIT}) & `~M_flush`. It is 0 in DONE and 0 when `M_mem_en`=0.
- `stall` = `mem_stall | E_stall_req`.
- `exmem_ena1` = `exmem_ena2` = `~stall`.
- `exmem_clear1` = `M_flush | (E_stall_req & ~mem_stall)`: inserts a bubble into M when EX holds but M drains.
- `exmem_clear2` = `exmem_clear1 | (E_slave_kill & ~stall)`.
- `M_rdata_valid`=0 outside DONE. `M_rdata` holds the buffer value at all times.

## Timing
- Bus outputs and EX/MEM controls are combinational from state and inputs. No comb path from `data_rdata` to any output other than via the buffer.
- Best case (`addr_ok` same cycle, `data_ok` next cycle):
  - c0 IDLE: req accepted.
  - c1 WAIT: `data_ok`.
  - c2 DONE: `mem_stall`=0; EX/MEM loads at end of c2.
  - `mem_stall` is high for 2 cycles.
- The next instruction with `M_mem_en` arriving the cycle after DONE issues immediately from IDLE. Back-to-back accesses therefore cost 3 cycles each minimum.
- `M_flush` is honoured in the same cycle: both clears high, `mem_stall` forced 0. Draining continues in the background. A new M access stalls until the drain completes.
- `rst` mid-transaction returns to IDLE with no drain. The bus slave is reset by the same `rst`.

## Test plan
- Load, `addr_ok` c0, `data_ok` c1 with rdata=0xDEADBEEF → `mem_stall` 1,1,0. `M_rdata_valid`=1 and `M_rdata`=0xDEADBEEF in c2. `exmem_ena1`=1 in c2.
- Store, `addr_ok` held 0 for 3 cycles → `data_req`, `data_addr`, `data_wdata` stable for all 4 cycles even if `M_mem_*` inputs change. `data_wr`=1.
- Load completes into DONE with `E_stall_req`=1 for 2 cycles → stays DONE, no second `data_req`. `exmem_clear1`=1 and `exmem_ena1`=0 in those cycles. IDLE after `E_stall_req` falls.
- `M_flush` in WAIT, `data_ok` two cycles later with 0x12345678 → clears high in the flush cycle. DRAIN_WAIT, buffer unchanged, `M_rdata_valid` never 1. A new M load stalls until the drain ends.
- `E_slave_kill`=1 with no stall → `exmem_clear2`=1, `exmem_clear1`=0. Same with `E_stall_req`=1 → `exmem_clear2`=1, both enables 0.
- `rst` asserted while in REQ → next cycle IDLE, `data_req`=0, all enables/clears per idle equations, `M_rdata`=0.
